// File: rtl/bilinear_window_interp_if.sv
// Bundles the window-beat input stream and the interpolated output stream.
// The window FIFO/controller side uses master; the interpolator uses slave.
// No backpressure: every qualified beat produces exactly one output pulse.
interface bilinear_window_interp_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAC       = 4,
  parameter int WIN_COLS   = 7,
  parameter int WIN_ROWS   = 7,
  parameter int OUT_WIDTH  = DATA_WIDTH + FRAC
);
  localparam int CW = $clog2(WIN_COLS);
  localparam int RW = $clog2(WIN_ROWS);

  logic                    load_frac;
  logic [FRAC-1:0]         frac_r;
  logic [FRAC-1:0]         frac_c;
  logic                    flush;
  logic                    in_valid;
  logic [2*DATA_WIDTH-1:0] d0;
  logic [2*DATA_WIDTH-1:0] d1;
  logic [2*DATA_WIDTH-1:0] d2;
  logic [2*DATA_WIDTH-1:0] d3;
  logic                    out_valid;
  logic [OUT_WIDTH-1:0]    out0;
  logic [OUT_WIDTH-1:0]    out1;
  logic [OUT_WIDTH-1:0]    out2;
  logic [CW-1:0]           out_col;
  logic [RW-1:0]           out_row;
  logic                    out_last;
  logic                    busy;
  logic                    err;

  modport master (
    output load_frac, frac_r, frac_c, flush, in_valid, d0, d1, d2, d3,
    input  out_valid, out0, out1, out2, out_col, out_row, out_last, busy, err
  );

  modport slave (
    input  load_frac, frac_r, frac_c, flush, in_valid, d0, d1, d2, d3,
    output out_valid, out0, out1, out2, out_col, out_row, out_last, busy, err
  );
endinterface

// File: rtl/bilinear_window_interp.sv
// Bilinear interpolator over 4-row x 2-column beats: three row-pair outputs per beat.
// Latency: beat accepted at edge N is presented after edge N+3, one beat per cycle.
// Backpressure: none; beats without a loaded fraction are dropped and flagged in err.
module bilinear_window_interp #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAC       = 4,
  parameter int WIN_COLS   = 7,
  parameter int WIN_ROWS   = 7,
  parameter int OUT_WIDTH  = DATA_WIDTH + FRAC
) (
  input logic                     clk,
  input logic                     rst,
  bilinear_window_interp_if.slave bus
);
  localparam int CW  = $clog2(WIN_COLS);
  localparam int RW  = $clog2(WIN_ROWS);
  localparam int PW  = 2 * DATA_WIDTH;
  localparam int HW  = DATA_WIDTH + FRAC;
  localparam int VW  = DATA_WIDTH + 2 * FRAC;
  localparam int ONE = 1 << FRAC;

  // Horizontal blend of one pixel pair; the true result never exceeds
  // max_pixel * 2^FRAC, so HW-bit arithmetic is exact.
  function automatic logic [HW-1:0] f_hmix(input logic [PW-1:0] px, input logic [FRAC-1:0] b);
    logic [HW-1:0] wr;
    logic [HW-1:0] wl;
    wr = HW'(b);
    wl = HW'(ONE) - wr;
    return HW'(px[PW-1:DATA_WIDTH]) * wl + HW'(px[DATA_WIDTH-1:0]) * wr;
  endfunction

  // Vertical blend of two horizontal results, full precision in VW bits.
  function automatic logic [VW-1:0] f_vmix(input logic [HW-1:0] h0, input logic [HW-1:0] h1,
                                            input logic [FRAC-1:0] a);
    logic [VW-1:0] wb;
    logic [VW-1:0] wt;
    wb = VW'(a);
    wt = VW'(ONE) - wb;
    return VW'(h0) * wt + VW'(h1) * wb;
  endfunction

  // Round half up and drop the vertical fraction bits.
  function automatic logic [OUT_WIDTH-1:0] f_round(input logic [VW-1:0] v);
    logic [VW:0] s;
    s = {1'b0, v} + (VW + 1)'(ONE / 2);
    return OUT_WIDTH'(s >> FRAC);
  endfunction

  // Window control state
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic            r_frac_loaded;
  logic [FRAC-1:0] r_frac_a;
  logic [FRAC-1:0] r_frac_b;
  logic            r_err;

  // Pipeline state: s0 = captured beat, s1 = horizontal, s2 = vertical, out = rounded
  logic            r_s0_vld, r_s1_vld, r_s2_vld, r_out_vld;
  logic [PW-1:0]   r_s0_px [4];
  logic [FRAC-1:0] r_s0_a, r_s0_b, r_s1_a;
  logic [HW-1:0]   r_s1_h [4];
  logic [VW-1:0]   r_s2_v [3];
  logic [OUT_WIDTH-1:0] r_out [3];
  logic [CW-1:0]   r_s0_col, r_s1_col, r_s2_col, r_out_col;
  logic [RW-1:0]   r_s0_row, r_s1_row, r_s2_row, r_out_row;
  logic            r_s0_last, r_s1_last, r_s2_last, r_out_last;

  logic            w_pipe_busy, w_at_start, w_load_ok, w_load_bad;
  logic            w_frac_ok, w_accept, w_drop, w_col_end, w_row_end;
  logic [FRAC-1:0] w_cur_a, w_cur_b;
  logic [PW-1:0]   w_px [4];

  // Beat qualification, fraction load decision and window position decode
  always_comb begin
    w_pipe_busy = r_s0_vld | r_s1_vld | r_s2_vld | r_out_vld;
    w_at_start  = (r_row == '0) && (r_col == '0) && !w_pipe_busy;
    w_load_ok   = bus.load_frac && !bus.flush && w_at_start;
    w_load_bad  = bus.load_frac && !bus.flush && !w_at_start;
    w_frac_ok   = r_frac_loaded || w_load_ok;
    w_accept    = bus.in_valid && !bus.flush && w_frac_ok;
    w_drop      = bus.in_valid && !bus.flush && !w_frac_ok;
    // A load coinciding with the first beat applies to that beat
    w_cur_a     = w_load_ok ? bus.frac_r : r_frac_a;
    w_cur_b     = w_load_ok ? bus.frac_c : r_frac_b;
    w_col_end   = (r_col == CW'(WIN_COLS - 1));
    w_row_end   = (r_row == RW'(WIN_ROWS - 1));
    w_px[0]     = bus.d0;
    w_px[1]     = bus.d1;
    w_px[2]     = bus.d2;
    w_px[3]     = bus.d3;
  end

  // Window counters, fraction register and sticky error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col         <= '0;
      r_row         <= '0;
      r_frac_loaded <= 1'b0;
      r_frac_a      <= '0;
      r_frac_b      <= '0;
      r_err         <= 1'b0;
    end else begin
      if (w_load_bad || w_drop) r_err <= 1'b1;
      if (bus.flush) begin
        r_col         <= '0;
        r_row         <= '0;
        r_frac_loaded <= 1'b0;
      end else begin
        if (w_load_ok) begin
          r_frac_a      <= bus.frac_r;
          r_frac_b      <= bus.frac_c;
          r_frac_loaded <= 1'b1;
        end
        if (w_accept) begin
          if (w_col_end) begin
            r_col <= '0;
            if (w_row_end) begin
              r_row         <= '0;
              r_frac_loaded <= 1'b0;
            end else begin
              r_row <= r_row + 1'b1;
            end
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
      end
    end
  end

  // Pipeline valid bits; flush drops everything in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s0_vld  <= 1'b0;
      r_s1_vld  <= 1'b0;
      r_s2_vld  <= 1'b0;
      r_out_vld <= 1'b0;
    end else begin
      r_s0_vld  <= w_accept;
      r_s1_vld  <= r_s0_vld && !bus.flush;
      r_s2_vld  <= r_s1_vld && !bus.flush;
      r_out_vld <= r_s2_vld && !bus.flush;
    end
  end

  // Datapath and position tags; each stage only loads when its input is valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        r_s0_px[k] <= '0;
        r_s1_h[k]  <= '0;
      end
      for (int j = 0; j < 3; j++) begin
        r_s2_v[j] <= '0;
        r_out[j]  <= '0;
      end
      r_s0_a <= '0; r_s0_b <= '0; r_s1_a <= '0;
      r_s0_col <= '0; r_s1_col <= '0; r_s2_col <= '0; r_out_col <= '0;
      r_s0_row <= '0; r_s1_row <= '0; r_s2_row <= '0; r_out_row <= '0;
      r_s0_last <= 1'b0; r_s1_last <= 1'b0; r_s2_last <= 1'b0; r_out_last <= 1'b0;
    end else begin
      if (w_accept) begin
        for (int k = 0; k < 4; k++) r_s0_px[k] <= w_px[k];
        r_s0_a    <= w_cur_a;
        r_s0_b    <= w_cur_b;
        r_s0_col  <= r_col;
        r_s0_row  <= r_row;
        r_s0_last <= w_col_end && w_row_end;
      end
      if (r_s0_vld) begin
        for (int k = 0; k < 4; k++) r_s1_h[k] <= f_hmix(r_s0_px[k], r_s0_b);
        r_s1_a    <= r_s0_a;
        r_s1_col  <= r_s0_col;
        r_s1_row  <= r_s0_row;
        r_s1_last <= r_s0_last;
      end
      if (r_s1_vld) begin
        for (int j = 0; j < 3; j++) r_s2_v[j] <= f_vmix(r_s1_h[j], r_s1_h[j+1], r_s1_a);
        r_s2_col  <= r_s1_col;
        r_s2_row  <= r_s1_row;
        r_s2_last <= r_s1_last;
      end
      if (r_s2_vld) begin
        for (int j = 0; j < 3; j++) r_out[j] <= f_round(r_s2_v[j]);
        r_out_col  <= r_s2_col;
        r_out_row  <= r_s2_row;
        r_out_last <= r_s2_last;
      end
    end
  end

  assign bus.out_valid = r_out_vld;
  assign bus.out0      = r_out[0];
  assign bus.out1      = r_out[1];
  assign bus.out2      = r_out[2];
  assign bus.out_col   = r_out_col;
  assign bus.out_row   = r_out_row;
  assign bus.out_last  = r_out_last;
  assign bus.busy      = (r_row != '0) || (r_col != '0) || w_pipe_busy;
  assign bus.err       = r_err;
endmodule
